// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// -----------------------------------------------------------------------------
// Data-memory access stage sitting between EX/MEM and MEM/WB. It holds a
// direct-mapped, write-back, write-allocate cache with one 32-bit word per
// line, in front of a slow handshaked data memory.
//
// A hit (load or store) completes in the cycle it is presented. A miss raises
// stall_o in that same cycle and holds it while the FSM writes back a dirty
// victim (WRITEBACK) and then fills the line (ALLOCATE). After the fill, the
// held request is re-evaluated in IDLE and completes as a hit.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : synchronous active-high reset
//   req_i        : pipeline access this cycle
//   wr_i         : 1 = store, 0 = load (qualified by req_i)
//   addr_i       : byte address; bits [1:0] ignored
//   wdata_i      : store data
//   rdata_o      : load data (zero unless a load hits in IDLE)
//   stall_o      : pipeline hold request
//   mem_enable_o : memory request, held until mem_ack_i
//   mem_write_o  : 1 = writeback, 0 = fill
//   mem_addr_o   : word-aligned memory address
//   mem_wdata_o  : victim data for writeback
//   mem_ack_i    : one-cycle completion pulse from memory
//   mem_rdata_i  : fill data, valid in the mem_ack_i cycle
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_enable_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Address split of the live request
    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] tag;
    assign idx = addr_i[2+IDX-1:2];
    assign tag = addr_i[31:2+IDX];

    // Byte-offset bits are intentionally ignored (word accesses only)
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // Line storage; tag/data are never cleared, only valid/dirty are
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];
    logic [LINES-1:0] valid_reg, valid_next;
    logic [LINES-1:0] dirty_reg, dirty_next;

    // Miss address captured when the miss is first seen; later changes on
    // addr_i during the miss are not looked at
    logic [TAG_W-1:0] miss_tag_reg;
    logic [IDX-1:0]   miss_idx_reg;

    // Registered memory interface
    logic        mem_enable_reg, mem_enable_next;
    logic        mem_write_reg,  mem_write_next;
    logic [31:0] mem_addr_reg,   mem_addr_next;
    logic [31:0] mem_wdata_reg,  mem_wdata_next;

    logic in_idle;
    logic hit;
    logic hit_store;
    logic miss_start;
    logic wb_done;
    logic fill_done;

    assign in_idle    = (state_reg == IDLE);
    assign hit        = valid_reg[idx] && (tag_arr[idx] == tag);
    assign hit_store  = in_idle && req_i && wr_i && hit;
    assign miss_start = in_idle && req_i && !hit;
    assign wb_done    = (state_reg == WRITEBACK) && mem_ack_i;
    assign fill_done  = (state_reg == ALLOCATE) && mem_ack_i;

    // Pipeline-facing outputs are combinational so a hit costs no cycle
    assign stall_o = req_i && !(in_idle && hit);
    assign rdata_o = (in_idle && req_i && !wr_i && hit) ? data_arr[idx] : 32'd0;

    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;

    // Per-line valid/dirty update
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_state
        logic is_miss_line;
        logic is_req_line;
        assign is_miss_line = (miss_idx_reg == IDX'(gi));
        assign is_req_line  = (idx == IDX'(gi));

        assign valid_next[gi] = (fill_done && is_miss_line) ? 1'b1 : valid_reg[gi];

        // A store hit dirties the line; a completed writeback or a fresh fill
        // leaves it clean
        assign dirty_next[gi] = (hit_store && is_req_line)                ? 1'b1 :
                                ((wb_done || fill_done) && is_miss_line) ? 1'b0 :
                                dirty_reg[gi];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            dirty_reg <= dirty_next;
        end
    end

    // Single write port into the line arrays: store hit or fill, which can
    // never happen in the same cycle since they belong to different states
    logic           data_we;
    logic [IDX-1:0] data_waddr;
    logic [31:0]    data_wdata;
    assign data_we    = (hit_store || fill_done) && !rst_i;
    assign data_waddr = fill_done ? miss_idx_reg : idx;
    assign data_wdata = fill_done ? mem_rdata_i : wdata_i;

    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_arr[data_waddr] <= data_wdata;
        end
        if (fill_done && !rst_i) begin
            tag_arr[miss_idx_reg] <= miss_tag_reg;
        end
    end

    // FSM state and memory-interface registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            miss_tag_reg   <= '0;
            miss_idx_reg   <= '0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
        end else begin
            state_reg      <= state_next;
            mem_enable_reg <= mem_enable_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            if (miss_start) begin
                miss_tag_reg <= tag;
                miss_idx_reg <= idx;
            end
        end
    end

    // Next state and the memory-interface values for the state being entered
    always_comb begin
        state_next      = state_reg;
        mem_enable_next = mem_enable_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (miss_start) begin
                    if (valid_reg[idx] && dirty_reg[idx]) begin
                        // Evict the victim first, addressed by its own tag
                        state_next      = WRITEBACK;
                        mem_enable_next = 1'b1;
                        mem_write_next  = 1'b1;
                        mem_addr_next   = {tag_arr[idx], idx, 2'b00};
                        mem_wdata_next  = data_arr[idx];
                    end else begin
                        state_next      = ALLOCATE;
                        mem_enable_next = 1'b1;
                        mem_write_next  = 1'b0;
                        mem_addr_next   = {tag, idx, 2'b00};
                        mem_wdata_next  = 32'd0;
                    end
                end
            end

            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_next      = ALLOCATE;
                    mem_enable_next = 1'b1;
                    mem_write_next  = 1'b0;
                    mem_addr_next   = {miss_tag_reg, miss_idx_reg, 2'b00};
                    mem_wdata_next  = 32'd0;
                end
            end

            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_next      = IDLE;
                    mem_enable_next = 1'b0;
                    mem_write_next  = 1'b0;
                    mem_addr_next   = 32'd0;
                    mem_wdata_next  = 32'd0;
                end
            end

            default: begin
                state_next      = IDLE;
                mem_enable_next = 1'b0;
                mem_write_next  = 1'b0;
                mem_addr_next   = 32'd0;
                mem_wdata_next  = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
// -----------------------------------------------------------------------------
// Bench for dcache_ctrl (LINES = 32). Inputs are applied on the falling edge,
// outputs are sampled 1 ns before the next rising edge. The main walk-through
// is a table of per-cycle vectors; reset-mid-miss and request-drop are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        wr_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_enable_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.LINES(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] mrd;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic        e_en;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic req, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic ack, logic [31:0] mrd, logic e_stall, logic [31:0] e_rdata,
                                logic e_en, logic e_mwr, logic [31:0] e_maddr, logic [31:0] e_mwdata);
        vec_t v;
        v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.mrd = mrd;
        v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_en = e_en; v.e_mwr = e_mwr;
        v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; sampling happens 4 ns later
    task automatic drive(input logic rst, input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ack, input logic [31:0] mrd);
        @(negedge clk_i);
        rst_i = rst; req_i = req; wr_i = wr; addr_i = addr; wdata_i = wdata;
        mem_ack_i = ack; mem_rdata_i = mrd;
        #4;
    endtask

    task automatic check_all(input string tag, input int step, input logic e_stall, input logic [31:0] e_rdata,
                             input logic e_en, input logic e_mwr, input logic [31:0] e_maddr,
                             input logic [31:0] e_mwdata);
        check({tag, ".stall"}, step, {31'd0, stall_o}, {31'd0, e_stall});
        check({tag, ".rdata"}, step, rdata_o, e_rdata);
        check({tag, ".mem_en"}, step, {31'd0, mem_enable_o}, {31'd0, e_en});
        if (e_en) begin
            check({tag, ".mem_wr"}, step, {31'd0, mem_write_o}, {31'd0, e_mwr});
            check({tag, ".mem_addr"}, step, mem_addr_o, e_maddr);
            if (e_mwr) check({tag, ".mem_wdata"}, step, mem_wdata_o, e_mwdata);
        end
        $display("%s step %0d: req=%0b wr=%0b addr=%h ack=%0b -> stall=%0b rdata=%h en=%0b mwr=%0b maddr=%h mwdata=%h",
                 tag, step, req_i, wr_i, addr_i, mem_ack_i, stall_o, rdata_o,
                 mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; wr_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;

        // ---------------- reset ----------------
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("reset.stall", 0, {31'd0, stall_o}, 32'd0);
        check("reset.rdata", 0, rdata_o, 32'd0);
        check("reset.mem_en", 0, {31'd0, mem_enable_o}, 32'd0);
        check("reset.mem_wr", 0, {31'd0, mem_write_o}, 32'd0);
        check("reset.mem_addr", 0, mem_addr_o, 32'd0);
        check("reset.mem_wdata", 0, mem_wdata_o, 32'd0);
        $display("reset: stall=%0b rdata=%h en=%0b mwr=%0b maddr=%h mwdata=%h",
                 stall_o, rdata_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o);

        // ---------------- table ----------------
        //            req wr addr          wdata         ack mrd          | stall rdata        en mwr maddr         mwdata
        // clean load miss of 0x40, ack on the third ALLOCATE cycle
        vecs[0]  = mk(1, 0, 32'h40,  32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[1]  = mk(1, 0, 32'h40,  32'h0,         0, 32'h0,         1, 32'h0,         1, 0, 32'h40,  32'h0);
        vecs[2]  = mk(1, 0, 32'h40,  32'h0,         0, 32'h0,         1, 32'h0,         1, 0, 32'h40,  32'h0);
        vecs[3]  = mk(1, 0, 32'h40,  32'h0,         1, 32'hDEADBEEF,  1, 32'h0,         1, 0, 32'h40,  32'h0);
        vecs[4]  = mk(1, 0, 32'h40,  32'h0,         0, 32'h0,         0, 32'hDEADBEEF,  0, 0, 32'h0,   32'h0);
        // repeat load: plain hit
        vecs[5]  = mk(1, 0, 32'h40,  32'h0,         0, 32'h0,         0, 32'hDEADBEEF,  0, 0, 32'h0,   32'h0);
        // store hit, then conflicting load 0xC0 forces writeback of 0x40
        vecs[6]  = mk(1, 1, 32'h40,  32'h12345678,  0, 32'h0,         0, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[7]  = mk(1, 0, 32'hC0,  32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[8]  = mk(1, 1, 32'h40,  32'hFFFFFFFF,  0, 32'h0,         1, 32'h0,         1, 1, 32'h40,  32'h12345678);
        vecs[9]  = mk(1, 0, 32'hC0,  32'h0,         1, 32'h0,         1, 32'h0,         1, 1, 32'h40,  32'h12345678);
        vecs[10] = mk(1, 0, 32'h44,  32'h0,         1, 32'hCAFE0001,  1, 32'h0,         1, 0, 32'hC0,  32'h0);
        vecs[11] = mk(1, 0, 32'hC0,  32'h0,         0, 32'h0,         0, 32'hCAFE0001,  0, 0, 32'h0,   32'h0);
        // store miss to 0x100 (write-allocate), then read it back
        vecs[12] = mk(1, 1, 32'h100, 32'hAABBCCDD,  0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[13] = mk(1, 1, 32'h100, 32'hAABBCCDD,  1, 32'h0,         1, 32'h0,         1, 0, 32'h100, 32'h0);
        vecs[14] = mk(1, 1, 32'h100, 32'hAABBCCDD,  0, 32'h0,         0, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[15] = mk(1, 0, 32'h100, 32'h0,         0, 32'h0,         0, 32'hAABBCCDD,  0, 0, 32'h0,   32'h0);
        // evicting 0x100 with 0x180 writes the stored word back
        vecs[16] = mk(1, 0, 32'h180, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[17] = mk(1, 0, 32'h180, 32'h0,         1, 32'h0,         1, 32'h0,         1, 1, 32'h100, 32'hAABBCCDD);
        vecs[18] = mk(1, 0, 32'h180, 32'h0,         1, 32'h00000180,  1, 32'h0,         1, 0, 32'h180, 32'h0);
        vecs[19] = mk(1, 0, 32'h180, 32'h0,         0, 32'h0,         0, 32'h00000180,  0, 0, 32'h0,   32'h0);
        // stray ack in IDLE is ignored
        vecs[20] = mk(0, 0, 32'h180, 32'h0,         1, 32'hFFFF0000,  0, 32'h0,         0, 0, 32'h0,   32'h0);
        vecs[21] = mk(1, 0, 32'h180, 32'h0,         0, 32'h0,         0, 32'h00000180,  0, 0, 32'h0,   32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(1'b0, vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].mrd);
            check_all("vec", i, vecs[i].e_stall, vecs[i].e_rdata, vecs[i].e_en, vecs[i].e_mwr,
                      vecs[i].e_maddr, vecs[i].e_mwdata);
        end

        // ---------------- reset during ALLOCATE ----------------
        // Line 16 currently holds 0xC0 (valid, clean); 0x40 misses to ALLOCATE
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        check_all("rstmiss", 0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        check_all("rstmiss", 1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        // reset coincides with an ack that must be dropped
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h55555555);
        drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        check_all("rstmiss", 2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rstmiss.mem_addr", 2, mem_addr_o, 32'h0);
        // late ack after reset is ignored
        drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h66666666);
        check_all("rstmiss", 3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        // 0xC0 was valid before reset; now it must miss
        drive(1'b0, 1'b1, 1'b0, 32'hC0, 32'h0, 1'b0, 32'h0);
        check_all("rstmiss", 4, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'hC0, 32'h0, 1'b1, 32'h0BADF00D);
        check_all("rstmiss", 5, 1'b1, 32'h0, 1'b1, 1'b0, 32'hC0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'hC0, 32'h0, 1'b0, 32'h0);
        check_all("rstmiss", 6, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- request dropped mid-miss ----------------
        // 0x200 maps to line 0, which is invalid after the reset
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        check_all("drop", 0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        check_all("drop", 1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 32'h00000077);
        check_all("drop", 2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        check_all("drop", 3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        // the fill finished on its own, so the load now hits
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        check_all("drop", 4, 1'b0, 32'h00000077, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-memory access stage between EX/MEM and the MEM/WB pipeline register.
- Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line, sitting in front of a slow handshaked data memory.
- Serves pipeline loads and stores in one cycle on a hit.
- Raises a stall on a miss; the stall drives the mem_stall_i hold of MEM/WB and freezes the upstream pipeline registers.

Parameters:
- LINES, 32: number of cache lines; power of two, at least 2; IDX = log2(LINES).
- TAG_W, 30-IDX: tag width, taken from addr bits [31:2+IDX].

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- req_i  input  1  pipeline access this cycle (MemRead or MemWrite)
- wr_i  input  1  1 = store, 0 = load; qualified by req_i
- addr_i  input  32  byte address; bits [1:0] ignored
- wdata_i  input  32  store data
- rdata_o  output  32  load data to MEM/WB Memdata_i
- stall_o  output  1  pipeline hold request
- mem_enable_o  output  1  memory request, held until ack
- mem_write_o  output  1  1 = memory write (writeback), 0 = read (fill)
- mem_addr_o  output  32  word-aligned memory address
- mem_wdata_o  output  32  victim data for writeback
- mem_ack_i  input  1  one-cycle completion pulse from memory
- mem_rdata_i  input  32  fill data, valid in the mem_ack_i cycle

Behaviour:
- Address split: idx = addr_i[2+IDX-1:2], tag = addr_i[31:2+IDX].
- Per-line state: valid, dirty, tag and data arrays.
- hit = valid[idx] & (tag_arr[idx] == tag).

Reset (rst_i = 1 at an edge):
- All valid and dirty bits clear; state returns to IDLE.
- Tag and data arrays are not cleared.
- Outputs after reset: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0, stall_o = 0, rdata_o = 0.
- Reset mid-miss abandons the transaction: mem_enable_o is 0 from the next cycle, and any in-flight ack is ignored.

Combinational outputs:
- stall_o = req_i & ~(state == IDLE & hit). It asserts in the same cycle a miss is presented.
- rdata_o = data_arr[idx] when state == IDLE, req_i, ~wr_i and hit; otherwise 0.

FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, req_i & hit & wr_i: at the edge, data_arr[idx] <= wdata_i and dirty[idx] <= 1. No stall.
- IDLE, req_i & ~hit: latch miss address; go to WRITEBACK if valid[idx] & dirty[idx], else ALLOCATE.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {tag_arr[idx], idx, 2'b00}; mem_wdata_o = data_arr[idx].
  - On mem_ack_i: dirty[idx] <= 0, go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {latched tag, idx, 2'b00}.
  - On mem_ack_i: data <= mem_rdata_i, tag <= latched tag, valid <= 1, dirty <= 0; go to IDLE.
- Memory outputs are registered and take their values in the cycle the state is entered.

Latency and sequencing:
- After a fill, IDLE re-evaluates the held request as a hit next cycle: a load returns data and a store writes (write-allocate).
- Clean miss latency: stall cycles = 1 + (cycles until ack) + 0; the hit completes in the cycle after the fill ack.
- Dirty miss: one writeback transaction, then the fill.

Boundary conditions:
- mem_ack_i is ignored in IDLE.
- If req_i drops mid-miss, the FSM completes the writeback and fill anyway and then idles.
- addr_i and wr_i changes during the miss are not sampled; the latched tag and idx are used.
- Two addresses with the same idx and different tags evict each other, writing back when dirty.

Test Plan:
- Reset, then load addr 0x0000_0040 with memory acking after 3 cycles returning 0xDEAD_BEEF → stall_o high 4 cycles, mem_addr_o = 0x40 with mem_write_o = 0; next cycle rdata_o = 0xDEAD_BEEF, stall_o = 0.
- Repeat the same load → no stall, rdata_o = 0xDEAD_BEEF in the same cycle, mem_enable_o stays 0.
- Store 0x1234_5678 to 0x40 (hit), then load 0x40 + LINES*4 (same index, LINES = 32 so 0xC0) → WRITEBACK to 0x40 with data 0x1234_5678, then ALLOCATE read of 0xC0.
- Store miss to 0x100 with fill data 0 → after the fill, the store lands; a load of 0x100 returns the store data and the line is dirty (next eviction writes it back).
- Assert rst_i during ALLOCATE → mem_enable_o = 0 next cycle, stall_o = 0 with req_i low, and a reload of 0x40 misses because valid is cleared.
- Drop req_i one cycle into a miss → the fill still completes; mem_enable_o falls after the ack, and stall_o = 0.
